// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - opcodes, FSM state type and opcode predicate shared by the nibble sequencer
package alu4_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_PASA = 3'b100;
  localparam logic [2:0] OP_PASB = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // ADD and SUB are the only opcodes that chain carry and produce C/V
  function automatic logic is_arith(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu4_seq_ctrl_if.sv
// rtl/alu4_seq_ctrl_if.sv - command handshake and result/flag bundle of the nibble sequencer
interface alu4_seq_ctrl_if #(parameter int NIB = 4);

  localparam int W = 4 * NIB;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c;
  logic         n;
  logic         z;
  logic         v;

  modport master (
    output cmd_valid, op, a, b,
    input  cmd_ready, busy, done, result, c, n, z, v
  );

  modport slave (
    input  cmd_valid, op, a, b,
    output cmd_ready, busy, done, result, c, n, z, v
  );

endinterface

// File: rtl/alu4_slice.sv
// rtl/alu4_slice.sv - combinational 4-bit ALU slice with carry in/out and carry into bit 3
module alu4_slice
  import alu4_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] r4,
  output logic       co,
  output logic       c3
);

  logic [3:0] bx;
  logic [4:0] sum;

  // SUB adds the inverted B; the +1 arrives through cin on the first nibble
  always_comb begin
    bx  = (op == OP_SUB) ? ~b4 : b4;
    sum = {1'b0, a4} + {1'b0, bx} + {4'b0000, cin};
    r4  = 4'h0;
    co  = 1'b0;
    c3  = 1'b0;
    case (op)
      OP_AND:  r4 = a4 & b4;
      OP_OR:   r4 = a4 | b4;
      OP_XOR:  r4 = a4 ^ b4;
      OP_NOTA: r4 = ~a4;
      OP_PASA: r4 = a4;
      OP_PASB: r4 = b4;
      default: begin
        r4 = sum[3:0];
        co = sum[4];
        // carry into bit 3 recovered from the bit-3 sum and its operands
        c3 = a4[3] ^ bx[3] ^ sum[3];
      end
    endcase
  end

endmodule

// File: rtl/alu4_seq_ctrl.sv
// rtl/alu4_seq_ctrl.sv - runs NIB-nibble ALU commands through one 4-bit slice, LSB nibble first
module alu4_seq_ctrl
  import alu4_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic clk,
  input  logic reset_n,
  alu4_seq_ctrl_if.slave bus
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t state;
  state_t state_next;

  logic [IW-1:0]        idx;
  logic                 carry;
  logic [2:0]           op_q;
  logic [NIB-1:0][3:0]  a_q;
  logic [NIB-1:0][3:0]  b_q;
  logic [NIB-1:0][3:0]  shadow;
  logic [NIB-1:0][3:0]  word_next;
  logic [NIB-1:0][3:0]  result_q;
  logic                 c_q;
  logic                 n_q;
  logic                 z_q;
  logic                 v_q;

  logic [3:0] r4;
  logic       co;
  logic       c3;

  alu4_slice u_slice (
    .op  (op_q),
    .a4  (a_q[idx]),
    .b4  (b_q[idx]),
    .cin (carry),
    .r4  (r4),
    .co  (co),
    .c3  (c3)
  );

  // shadow word with the current nibble merged in; becomes the result on the last pass
  always_comb begin
    word_next      = shadow;
    word_next[idx] = r4;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // next-state and handshake/status outputs, all decoded from the state
  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // command latch, nibble pass bookkeeping and whole-word commit of result and flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      shadow   <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= '0;
            carry <= (bus.op == OP_SUB);
          end
        end
        RUN: begin
          shadow <= word_next;
          carry  <= co;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            result_q <= word_next;
            c_q      <= is_arith(op_q) & co;
            v_q      <= is_arith(op_q) & (co ^ c3);
            n_q      <= word_next[NIB-1][3];
            z_q      <= (word_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.c      = c_q;
  assign bus.n      = n_q;
  assign bus.z      = z_q;
  assign bus.v      = v_q;

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// tb/tb_alu4_seq_ctrl.sv - directed scoreboard bench for alu4_seq_ctrl at NIB=4 and NIB=1
module tb_alu4_seq_ctrl;
  import alu4_pkg::*;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        n;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  alu4_seq_ctrl_if #(.NIB(4)) bus4 ();
  alu4_seq_ctrl_if #(.NIB(1)) bus1 ();

  alu4_seq_ctrl #(.NIB(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  alu4_seq_ctrl #(.NIB(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_of(input int w);
    return (w == 4) ? bus4.cmd_ready : bus1.cmd_ready;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? bus4.done : bus1.done;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 4) ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic [15:0] res_of(input int w);
    return (w == 4) ? bus4.result : {12'h000, bus1.result};
  endfunction

  function automatic logic [3:0] flags_of(input int w);
    return (w == 4) ? {bus4.c, bus4.n, bus4.z, bus4.v} : {bus1.c, bus1.n, bus1.z, bus1.v};
  endfunction

  task automatic drive(input int w, input logic vld, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 4) begin
      bus4.cmd_valid = vld; bus4.op = op; bus4.a = a; bus4.b = b;
    end else begin
      bus1.cmd_valid = vld; bus1.op = op; bus1.a = a[3:0]; bus1.b = b[3:0];
    end
  endtask

  task automatic push_exp(input logic [15:0] r, input logic c, input logic n,
                          input logic z, input logic v);
    exp_t e;
    e.r = r; e.c = c; e.n = n; e.z = z; e.v = v;
    sb.push_back(e);
  endtask

  task automatic compare_pop(input int w, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "/result"}, res_of(w), e.r);
    chk({tag, "/cnzv"}, flags_of(w), {e.c, e.n, e.z, e.v});
  endtask

  // called at #1 after the acceptance edge
  task automatic wait_done(input int w, input string tag, input int lat);
    int edges = 0;
    chk({tag, "/busy"}, busy_of(w), 1'b1);
    while (!done_of(w) && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "/done_seen"}, done_of(w), 1'b1);
    chk({tag, "/latency"}, edges, lat);
    compare_pop(w, tag);
    @(posedge clk); #1;
    chk({tag, "/pulse1"}, done_of(w), 1'b0);
  endtask

  task automatic issue(input int w, input string tag, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic c, input logic n,
                       input logic z, input logic v);
    int waited = 0;
    while (!ready_of(w) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, "/ready"}, ready_of(w), 1'b1);
    drive(w, 1'b1, op, a, b);
    push_exp(r, c, n, z, v);
    @(posedge clk); #1;
    drive(w, 1'b0, op, a, b);
    wait_done(w, tag, (w == 4) ? 4 : 1);
  endtask

  initial begin
    int ready_low;
    logic saw_done;
    logic any_done;

    reset_n = 1'b0;
    drive(4, 1'b0, OP_AND, 16'h0, 16'h0);
    drive(1, 1'b0, OP_AND, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", bus4.cmd_ready, 1'b1);
    chk("rst/busy", bus4.busy, 1'b0);
    chk("rst/done", bus4.done, 1'b0);
    chk("rst/result", bus4.result, 16'h0000);
    chk("rst/cnzv", {bus4.c, bus4.n, bus4.z, bus4.v}, 4'b0000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(4, "add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4, "sub_eq",   OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4, "sub_brw",  OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4, "sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4, "xor_zero", OP_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4, "not_a",    OP_NOTA, 16'h0F0F, 16'h1234, 16'hF0F0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4, "and",      OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4, "or",       OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4, "pass_a",   OP_PASA, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4, "pass_b",   OP_PASB, 16'hFFFF, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4, "add_carry", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // cmd_valid held high, operands churning while busy
    drive(4, 1'b1, OP_ADD, 16'h1111, 16'h2222);
    push_exp(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    ready_low = 0;
    saw_done  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.cmd_ready) break;
      ready_low++;
      if (bus4.done) begin
        saw_done = 1'b1;
        compare_pop(4, "hold/first");
      end
      drive(4, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom()), 16'($urandom()));
      @(posedge clk); #1;
    end
    chk("hold/first_done", saw_done, 1'b1);
    chk("hold/ready_low", ready_low, 5);
    drive(4, 1'b1, OP_ADD, 16'h0100, 16'h0001);
    push_exp(16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, OP_ADD, 16'h0, 16'h0);
    wait_done(4, "hold/second", 4);

    // reset while the third nibble is pending
    drive(4, 1'b1, OP_ADD, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    drive(4, 1'b0, OP_ADD, 16'h0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrst/ready", bus4.cmd_ready, 1'b1);
    chk("midrst/busy", bus4.busy, 1'b0);
    chk("midrst/done", bus4.done, 1'b0);
    chk("midrst/result", bus4.result, 16'h0000);
    chk("midrst/cnzv", {bus4.c, bus4.n, bus4.z, bus4.v}, 4'b0000);
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_done = any_done | bus4.done;
      @(posedge clk); #1;
    end
    chk("midrst/no_done", any_done, 1'b0);
    issue(4, "after_rst", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(1, "n1_add", OP_ADD, 16'h0007, 16'h0001, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(1, "n1_sub", OP_SUB, 16'h0003, 16'h0005, 16'h000E, 1'b0, 1'b1, 1'b0, 1'b0);

    chk("sb/drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
